// File: rtl/present_round_engine.sv
// present_round_engine: iterative PRESENT encryption core, one round per clock,
// with an on-the-fly key schedule and valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/pt/key    block input handshake (pt 64b, key 80b or 128b)
//   out_valid/out_ready/ct      ciphertext output handshake (ct 64b)
//   busy                        high while rounds are running
// Optional feature: define PRESENT_KEY128_EN for a 128-bit key and key schedule.
// Latency: NROUNDS edges from accept to out_valid; ct held until out_ready.

module present_sbox (
  input  logic [3:0] x_i,
  output logic [3:0] y_o
);
  always_comb begin
    y_o = 4'h0;
    case (x_i)
      4'h0: y_o = 4'hC;
      4'h1: y_o = 4'h5;
      4'h2: y_o = 4'h6;
      4'h3: y_o = 4'hB;
      4'h4: y_o = 4'h9;
      4'h5: y_o = 4'h0;
      4'h6: y_o = 4'hA;
      4'h7: y_o = 4'hD;
      4'h8: y_o = 4'h3;
      4'h9: y_o = 4'hE;
      4'hA: y_o = 4'hF;
      4'hB: y_o = 4'h8;
      4'hC: y_o = 4'h4;
      4'hD: y_o = 4'h7;
      4'hE: y_o = 4'h1;
      default: y_o = 4'h2;
    endcase
  end
endmodule

module present_round_engine #(
  parameter int unsigned NROUNDS = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  pt,
`ifdef PRESENT_KEY128_EN
  input  logic [127:0] key,
`else
  input  logic [79:0]  key,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  ct,
  output logic         busy
);
  localparam int KW = $bits(key);
  localparam logic [4:0] LAST_RC = 5'(NROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  st_t          st_q, st_d;
  logic [63:0]  state_q, state_d;
  logic [KW-1:0] key_q, key_d;
  logic [4:0]   rc_q, rc_d;
  logic [63:0]  ct_q, ct_d;

  // Round datapath: addRoundKey -> sbox layer -> pLayer
  logic [63:0] rk, sb_in, sb_out, p_out;
  assign rk    = key_q[KW-1:KW-64];
  assign sb_in = state_q ^ rk;

  for (genvar j = 0; j < 16; j++) begin : g_sbox
    present_sbox u_sbox (.x_i(sb_in[4*j+3:4*j]), .y_o(sb_out[4*j+3:4*j]));
  end

  always_comb begin
    p_out = '0;
    for (int i = 0; i < 63; i++) p_out[(16*i) % 63] = sb_out[i];
    p_out[63] = sb_out[63];
  end

  // Key schedule: rotate left by 61, sbox the top nibble(s), fold in rc
  logic [KW-1:0] rot, ks;
  logic [3:0]    ks_sb_hi;
  assign rot = {key_q[KW-62:0], key_q[KW-1:KW-61]};

  present_sbox u_ks_sbox_hi (.x_i(rot[KW-1:KW-4]), .y_o(ks_sb_hi));

`ifdef PRESENT_KEY128_EN
  logic [3:0] ks_sb_lo;
  present_sbox u_ks_sbox_lo (.x_i(rot[123:120]), .y_o(ks_sb_lo));

  always_comb begin
    ks           = rot;
    ks[127:124]  = ks_sb_hi;
    ks[123:120]  = ks_sb_lo;
    ks[66:62]    = rot[66:62] ^ rc_q;
  end
`else
  always_comb begin
    ks         = rot;
    ks[79:76]  = ks_sb_hi;
    ks[19:15]  = rot[19:15] ^ rc_q;
  end
`endif

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    ct_d    = ct_q;
    case (st_q)
      IDLE: begin
        if (in_valid) begin
          state_d = pt;
          key_d   = key;
          rc_d    = 5'd1;
          st_d    = RUN;
        end
      end
      RUN: begin
        state_d = p_out;
        key_d   = ks;
        rc_d    = rc_q + 5'd1;
        if (rc_q == LAST_RC) begin
          // Final whitening key is the schedule output of the last round
          ct_d = p_out ^ ks[KW-1:KW-64];
          st_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      rc_q    <= '0;
      ct_q    <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      ct_q    <= ct_d;
    end
  end

  assign in_ready  = (st_q == IDLE);
  assign out_valid = (st_q == DONE);
  assign busy      = (st_q == RUN);
  assign ct        = ct_q;

endmodule
